// File: rtl/iir_slot_pkg.sv
// Shared definitions for the IIR slot controller: state encoding and default widths.
package iir_slot_pkg;

    localparam int DW_DEF     = 10;
    localparam int CW_DEF     = 16;
    localparam int NCOEF_DEF  = 5;
    localparam int UNITY_COEF = 16384;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } slot_state_t;

endpackage

// File: rtl/iir_slot_keep_pipe.sv
// Keep-flag delay line that tracks each filter advance through the IIR latency.
module iir_slot_keep_pipe #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flag_in,
    output logic flag_out
);

    logic [LAT-1:0] sr;

    generate
        if (LAT == 1) begin : g_one
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sr <= '0;
                else       sr <= flag_in;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sr <= '0;
                else       sr <= {sr[LAT-2:0], flag_in};
            end
        end
    endgenerate

    assign flag_out = sr[LAT-1];

endmodule

// File: rtl/iir_slot_ctrl.sv
// Per-slot sequencer for the receiver IIR filter: coefficient push, sample gating,
// settle discard and tail flush. Optional bypass slots under IIR_SLOT_BYPASS_EN.
//
// state | meaning
// IDLE  | waiting for start; host coefficient writes accepted
// CLR   | one-cycle filter state clear
// LOAD  | push shadow coefficients 0..NCOEF-1 over valid/ready
// RUN   | gate slot samples into the filter
// FLUSH | feed FLUSH_LEN zero samples to drain the filter tail
// DONE  | one-cycle done pulse
module iir_slot_ctrl
    import iir_slot_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int CW         = CW_DEF,
    parameter int NCOEF      = NCOEF_DEF,
    parameter int IIR_LAT    = 4,
    parameter int SETTLE_LEN = 32,
    parameter int FLUSH_LEN  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   slot_len,
`ifdef IIR_SLOT_BYPASS_EN
    input  logic          bypass,
`endif
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    output logic          cfg_err,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic [DW-1:0] iir_din,
    output logic          iir_en,
    output logic          iir_clr,
    output logic [CW-1:0] coef_data,
    output logic [2:0]    coef_idx,
    output logic          coef_vld,
    input  logic          coef_rdy,
    input  logic [DW-1:0] iir_dout,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          busy,
    output logic          done
);

    localparam logic [3:0]  NCOEF_L    = 4'(NCOEF);
    localparam logic [2:0]  LAST_K     = 3'(NCOEF - 1);
    localparam logic [15:0] SETTLE_L   = 16'(SETTLE_LEN);
    localparam logic [15:0] FLUSH_INIT = 16'(FLUSH_LEN - 1);

    // A shorter flush would let kept outputs still be in the filter when done fires.
    generate
        if (FLUSH_LEN < IIR_LAT + 1) begin : g_flush_len_check
            $error("iir_slot_ctrl: FLUSH_LEN must be >= IIR_LAT+1");
        end
    endgenerate

    slot_state_t   state, state_nxt;
    logic [15:0]   slot_len_q;
    logic [15:0]   cnt, cnt_nxt;
    logic [15:0]   flush_tmr;
    logic [2:0]    k;
    logic [CW-1:0] shadow [NCOEF];
    logic          byp_q;
    logic          cfg_ok;
    logic          take;
    logic          last_take;
    logic          keep_q;
    logic          keep_out;

`ifdef IIR_SLOT_BYPASS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          byp_q <= 1'b0;
        else if (state == ST_IDLE && start) byp_q <= bypass;
    end
`else
    assign byp_q = 1'b0;
`endif

    assign cnt_nxt   = cnt + 16'd1;
    assign take      = (state == ST_RUN) && din_vld;
    assign last_take = take && (cnt_nxt == slot_len_q);
    assign cfg_ok    = (state == ST_IDLE) && ({1'b0, cfg_addr} < NCOEF_L);

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        iir_clr   = (state == ST_CLR);
        coef_vld  = (state == ST_LOAD);
        coef_idx  = '0;
        coef_data = '0;
        if (state == ST_LOAD) begin
            coef_idx  = k;
            coef_data = shadow[k];
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef IIR_SLOT_BYPASS_EN
                    if (bypass) state_nxt = (slot_len == '0) ? ST_DONE : ST_RUN;
                    else        state_nxt = ST_CLR;
`else
                    state_nxt = ST_CLR;
`endif
                end
            end
            ST_CLR:  state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (coef_rdy && k == LAST_K)
                    state_nxt = (slot_len_q == '0) ? ST_FLUSH : ST_RUN;
            end
            ST_RUN: begin
                if (last_take) state_nxt = byp_q ? ST_DONE : ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_tmr == '0) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            slot_len_q <= '0;
            cnt        <= '0;
            k          <= '0;
            flush_tmr  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) slot_len_q <= slot_len;

            if (state == ST_IDLE) cnt <= '0;
            else if (take)        cnt <= cnt_nxt;

            if (state != ST_LOAD)               k <= '0;
            else if (coef_rdy && k != LAST_K)   k <= k + 3'd1;

            // Down-counter loaded while outside FLUSH so the first FLUSH cycle sees FLUSH_LEN-1.
            if (state != ST_FLUSH)      flush_tmr <= FLUSH_INIT;
            else if (flush_tmr != '0)   flush_tmr <= flush_tmr - 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
            for (int i = 0; i < NCOEF; i++)
                shadow[i] <= (i == 0) ? CW'(UNITY_COEF) : '0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) shadow[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iir_en   <= 1'b0;
            iir_din  <= '0;
            keep_q   <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            iir_en  <= (take && !byp_q) || (state == ST_FLUSH);
            iir_din <= (take && !byp_q) ? din : '0;
            keep_q  <= take && !byp_q && (cnt >= SETTLE_L);

            if (byp_q && state == ST_RUN) begin
                dout_vld <= din_vld;
                if (din_vld) dout <= din;
            end else begin
                dout_vld <= keep_out;
                if (keep_out) dout <= iir_dout;
            end
        end
    end

    // keep_q is aligned with iir_en, so the pipe exit lines up with iir_dout.
    iir_slot_keep_pipe #(
        .LAT (IIR_LAT)
    ) u_keep_pipe (
        .clk      (clk),
        .reset    (reset),
        .flag_in  (keep_q),
        .flag_out (keep_out)
    );

endmodule

// File: tb/tb_iir_slot_ctrl.sv
// Directed bench for iir_slot_ctrl: table of slot scenarios plus hand-written
// sequences for host write rejection and reset during a slot.
module tb_iir_slot_ctrl;

    localparam int DW        = 10;
    localparam int CW        = 16;
    localparam int NCOEF     = 5;
    localparam int IIR_LAT   = 4;
    localparam int SETTLE    = 32;
    localparam int FLUSH_LEN = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   slot_len = '0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [CW-1:0] cfg_wdata = '0;
    logic          cfg_err;
    logic [DW-1:0] din = '0;
    logic          din_vld = 1'b0;
    logic [DW-1:0] iir_din;
    logic          iir_en;
    logic          iir_clr;
    logic [CW-1:0] coef_data;
    logic [2:0]    coef_idx;
    logic          coef_vld;
    logic          coef_rdy = 1'b1;
    logic [DW-1:0] iir_dout;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          busy;
    logic          done;
`ifdef IIR_SLOT_BYPASS_EN
    logic          bypass = 1'b0;
`endif

    iir_slot_ctrl #(
        .DW(DW), .CW(CW), .NCOEF(NCOEF), .IIR_LAT(IIR_LAT),
        .SETTLE_LEN(SETTLE), .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .slot_len(slot_len),
`ifdef IIR_SLOT_BYPASS_EN
        .bypass(bypass),
`endif
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .din(din), .din_vld(din_vld), .iir_din(iir_din), .iir_en(iir_en), .iir_clr(iir_clr),
        .coef_data(coef_data), .coef_idx(coef_idx), .coef_vld(coef_vld), .coef_rdy(coef_rdy),
        .iir_dout(iir_dout), .dout(dout), .dout_vld(dout_vld), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Filter stand-in: pure IIR_LAT-cycle delay of iir_din, so dout equals the input sample.
    logic [DW-1:0] fpipe [IIR_LAT];
    always @(posedge clk) begin
        for (int j = IIR_LAT - 1; j > 0; j--) fpipe[j] <= fpipe[j-1];
        fpipe[0] <= iir_din;
    end
    assign iir_dout = fpipe[IIR_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; int val; } exp_t;
    exp_t sb_q[$];
    int   exp_coef [NCOEF];

    int n_en, n_clr, n_dv, n_done, n_err, n_xfer, n_load;
    int clr_cyc, done_cyc;
    int stall_left = 0;

    always @(negedge clk) begin
        if (reset) begin
            coef_rdy = 1'b1;
        end else begin
            if (stall_left > 0 && coef_vld && coef_idx == 3'd2) begin
                coef_rdy = 1'b0;
                stall_left--;
            end else begin
                coef_rdy = 1'b1;
            end
            if (coef_vld) begin
                n_load++;
                if (n_xfer < NCOEF) begin
                    check("coef_idx", int'(coef_idx), n_xfer);
                    check("coef_data", int'($signed(coef_data)), exp_coef[n_xfer]);
                end else begin
                    check("coef_extra_xfer", n_xfer, NCOEF - 1);
                end
                if (coef_rdy) n_xfer++;
            end
            if (iir_clr) begin n_clr++; clr_cyc = cyc; end
            if (iir_en) n_en++;
            if (cfg_err) n_err++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (dout_vld) begin
                n_dv++;
                if (sb_q.size() == 0) begin
                    check("dout_vld_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("dout_vld_time", cyc, e.cyc);
                    check("dout_value", int'($signed(dout)), e.val);
                end
            end
        end
    end

    task automatic set_default_coefs();
        exp_coef[0] = 16384;
        for (int j = 1; j < NCOEF; j++) exp_coef[j] = 0;
    endtask

    task automatic cfg_write(input int addr, input int data, input int exp_err);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_wdata = 16'(data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("cfg_err_pulse", int'(cfg_err), exp_err);
        @(posedge clk); #1;
        check("cfg_err_width", int'(cfg_err), 0);
        if (exp_err == 0) exp_coef[addr] = data;
    endtask

    task automatic run_slot(input int len, input bit alt, input int stall_n, input bit wr_run,
                            input int abort_at, input int exp_dv, input int exp_load,
                            input int exp_err);
        int s, last, i, ph, guard;
        bit vld;
        n_en = 0; n_clr = 0; n_dv = 0; n_done = 0; n_err = 0; n_xfer = 0; n_load = 0;
        clr_cyc = -1; done_cyc = -1;
        stall_left = stall_n;
        sb_q.delete();

        @(posedge clk); #1;
        s = cyc;
        start = 1'b1; slot_len = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;

        guard = 0;
        while (n_xfer < NCOEF && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("load_transfers", n_xfer, NCOEF);
        last = cyc - 1;

        i = 0; ph = 0;
        while (i < len) begin
            if (abort_at >= 0 && i == abort_at) begin
                check("pre_reset_dout_vld", int'(dout_vld), 1);
                #2 reset = 1'b1;
                #1;
                check("reset_busy", int'(busy), 0);
                check("reset_outputs_zero",
                      int'(|{cfg_err, iir_din, iir_en, iir_clr, coef_data, coef_idx,
                             coef_vld, dout, dout_vld, done}), 0);
                din_vld = 1'b0; din = '0; cfg_we = 1'b0;
                sb_q.delete();
                set_default_coefs();
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check("post_reset_busy", int'(busy), 0);
                return;
            end
            vld = alt ? (ph % 2 == 0) : 1'b1;
            din_vld = vld;
            din = vld ? 10'(i + 1) : '0;
            cfg_we = wr_run && (ph == 4);
            cfg_addr = 3'd1; cfg_wdata = 16'd999;
            if (vld) begin
                if (i >= SETTLE) sb_q.push_back('{cyc + IIR_LAT + 2, i + 1});
                last = cyc;
                i++;
            end
            @(posedge clk); #1;
            ph++;
        end
        din_vld = 1'b0; din = '0; cfg_we = 1'b0;

        guard = 0;
        while (n_done == 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_seen", n_done, 1);
        check("done_time", done_cyc, last + FLUSH_LEN + 1);
        check("clr_count", n_clr, 1);
        check("clr_time", clr_cyc, s + 1);
        check("load_cycles", n_load, exp_load);
        check("iir_en_cycles", n_en, len + FLUSH_LEN);
        check("dout_vld_count", n_dv, exp_dv);
        check("kept_pending", sb_q.size(), 0);
        check("cfg_err_count", n_err, exp_err);
        if (exp_dv > 0) check("dout_hold", int'($signed(dout)), len);
        @(negedge clk);
        check("done_width", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    typedef struct {
        int len; bit alt; int stall; bit wr;
        int exp_dv; int exp_load; int exp_err;
    } vec_t;
    vec_t vecs [7];

    initial begin
        vecs[0] = '{100, 1'b0, 0, 1'b0, 68, 5, 0};
        vecs[1] = '{100, 1'b0, 3, 1'b0, 68, 8, 0};
        vecs[2] = '{ 20, 1'b0, 0, 1'b1,  0, 5, 1};
        vecs[3] = '{  0, 1'b0, 0, 1'b0,  0, 5, 0};
        vecs[4] = '{ 33, 1'b0, 0, 1'b0,  1, 5, 0};
        vecs[5] = '{ 32, 1'b0, 0, 1'b0,  0, 5, 0};
        vecs[6] = '{ 64, 1'b1, 0, 1'b0, 32, 5, 0};

        set_default_coefs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_outputs_zero",
              int'(|{cfg_err, iir_din, iir_en, iir_clr, coef_data, coef_idx,
                     coef_vld, dout, dout_vld, done}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        cfg_write(0, 16384, 0);
        cfg_write(1, 100, 0);
        cfg_write(2, -200, 0);
        cfg_write(3, 50, 0);
        cfg_write(4, 7, 0);

        for (int v = 0; v < 7; v++)
            run_slot(vecs[v].len, vecs[v].alt, vecs[v].stall, vecs[v].wr, -1,
                     vecs[v].exp_dv, vecs[v].exp_load, vecs[v].exp_err);

        cfg_write(6, 1234, 1);
        run_slot(40, 1'b0, 0, 1'b0, -1, 8, 5, 0);

        cfg_write(3, 55, 0);
        run_slot(100, 1'b0, 0, 1'b0, 40, 0, 5, 0);
        run_slot(40, 1'b0, 0, 1'b0, -1, 8, 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
